// File: rtl/fifo_slot_ctrl.sv
// Control and sequencing for a DEPTH-slot FIFO built from enabled flops: handshakes,
// one-hot slot write enables, head-slot read select, occupancy flags and high-water mark.
module fifo_slot_ctrl #(
    parameter int DEPTH     = 8,
    parameter int AFULL_TH  = DEPTH - 2,
    parameter int AEMPTY_TH = 1,
    localparam int AW       = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic             rd_ready,
    output logic             rd_valid,
    output logic [DEPTH-1:0] slot_wr_en,
    output logic [AW-1:0]    rd_sel,
    output logic [AW:0]      count,
    output logic             full,
    output logic             empty,
    output logic             almost_full,
    output logic             almost_empty,
    output logic [AW:0]      hwm
);

    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_TH);
    localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY_TH);
    localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);

    typedef enum logic [1:0] {S_EMPTY, S_PARTIAL, S_FULL} state_t;

    state_t          state;
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic            push;
    logic            pop;
    logic [CW-1:0]   next_count;

    // Explicit wrap so non-power-of-two depths never walk into unused indices.
    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    assign full     = (state == S_FULL);
    assign empty    = (state == S_EMPTY);
    assign wr_ready = !full && !clr;
    assign rd_valid = !empty && !clr;
    assign push     = wr_valid && wr_ready;
    assign pop      = rd_valid && rd_ready;
    assign rd_sel   = rd_ptr;

    always_comb begin
        next_count = count;
        if (clr)
            next_count = '0;
        else if (push && !pop)
            next_count = count + 1'b1;
        else if (pop && !push)
            next_count = count - 1'b1;
    end

    always_comb begin
        slot_wr_en = '0;
        for (int i = 0; i < DEPTH; i++)
            slot_wr_en[i] = rst_n && push && (wr_ptr == AW'(i));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_EMPTY;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            almost_full  <= (AFULL_TH == 0);
            almost_empty <= (AEMPTY_TH >= 0);
            hwm          <= '0;
        end else if (clr) begin
            state        <= S_EMPTY;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            almost_full  <= (AFULL_TH == 0);
            almost_empty <= (AEMPTY_TH >= 0);
            hwm          <= '0;
        end else begin
            if (push)
                wr_ptr <= ptr_inc(wr_ptr);
            if (pop)
                rd_ptr <= ptr_inc(rd_ptr);
            count        <= next_count;
            almost_full  <= (next_count >= AFULL_C);
            almost_empty <= (next_count <= AEMPTY_C);
            if (next_count > hwm)
                hwm <= next_count;
            // Transitions only at the occupancy edges; push+pop together holds state.
            case (state)
                S_EMPTY:   if (push) state <= S_PARTIAL;
                S_PARTIAL: begin
                    if (push && !pop && count == DEPTH_C - 1'b1)
                        state <= S_FULL;
                    else if (pop && !push && count == CW'(1))
                        state <= S_EMPTY;
                end
                S_FULL:    if (pop) state <= S_PARTIAL;
                default:   state <= S_EMPTY;
            endcase
        end
    end

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (rst_n) begin
            m_assert: assert (!$isunknown({wr_valid, rd_ready, clr})
                              && $countones(slot_wr_en) <= 1
                              && count <= DEPTH_C)
                else $error("fifo_slot_ctrl: unknown control input, multi-hot write enable or count overflow");
        end
    end
`endif

endmodule

// File: tb/tb_fifo_slot_ctrl.sv
// Bench for fifo_slot_ctrl: DEPTH=8 and DEPTH=5 instances share stimulus; an occupancy/sequence
// model checks every cycle, and directed literal checks pin the model.
module tb_fifo_slot_ctrl;

    logic clk = 1'b0, rst_n = 1'b0, clr = 1'b0, wr_valid = 1'b0, rd_ready = 1'b0;

    logic       wr_ready8, rd_valid8, full8, empty8, af8, ae8;
    logic [7:0] en8;
    logic [2:0] rd_sel8;
    logic [3:0] count8, hwm8;
    logic       wr_ready5, rd_valid5, full5, empty5, af5, ae5;
    logic [4:0] en5;
    logic [2:0] rd_sel5;
    logic [3:0] count5, hwm5;

    fifo_slot_ctrl #(.DEPTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .wr_valid(wr_valid), .wr_ready(wr_ready8),
        .rd_ready(rd_ready), .rd_valid(rd_valid8), .slot_wr_en(en8), .rd_sel(rd_sel8),
        .count(count8), .full(full8), .empty(empty8), .almost_full(af8),
        .almost_empty(ae8), .hwm(hwm8));

    fifo_slot_ctrl #(.DEPTH(5)) dut5 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .wr_valid(wr_valid), .wr_ready(wr_ready5),
        .rd_ready(rd_ready), .rd_valid(rd_valid5), .slot_wr_en(en5), .rd_sel(rd_sel5),
        .count(count5), .full(full5), .empty(empty5), .almost_full(af5),
        .almost_empty(ae5), .hwm(hwm5));

    always #5 clk = ~clk;

    logic [7:0] en_a[2];
    logic [5:0] flg_a[2];
    logic [3:0] cnt_a[2], hwm_a[2];
    logic [2:0] sel_a[2];
    assign en_a[0]  = en8;
    assign en_a[1]  = {3'b000, en5};
    assign flg_a[0] = {wr_ready8, rd_valid8, full8, empty8, af8, ae8};
    assign flg_a[1] = {wr_ready5, rd_valid5, full5, empty5, af5, ae5};
    assign cnt_a[0] = count8;
    assign cnt_a[1] = count5;
    assign hwm_a[0] = hwm8;
    assign hwm_a[1] = hwm5;
    assign sel_a[0] = rd_sel8;
    assign sel_a[1] = rd_sel5;

    int total = 0, passed = 0;

    // Model state: occupancy, peak, push/pop sequence numbers and the slot contents.
    int cnt[2]  = '{0, 0};
    int hw[2]   = '{0, 0};
    int wp[2]   = '{0, 0};
    int rp[2]   = '{0, 0};
    int wd[2]   = '{0, 0};
    int head[2] = '{0, 0};
    int mem[2][8];
    logic [7:0] en_s[2];
    int sel_s[2];

    function automatic int dep(input int k);
        return (k == 0) ? 8 : 5;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    endtask

    // Model advances on every clock edge (or asynchronously on reset).
    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            for (int k = 0; k < 2; k++) begin
                int d, ps, pp;
                d = dep(k);
                if (!rst_n) begin
                    cnt[k] = 0; hw[k] = 0; wp[k] = 0; rp[k] = 0; wd[k] = 0; head[k] = 0;
                end else if (clr) begin
                    cnt[k] = 0; hw[k] = 0; wp[k] = 0; rp[k] = 0; head[k] = wd[k];
                end else begin
                    ps = (wr_valid && cnt[k] < d) ? 1 : 0;
                    pp = (rd_ready && cnt[k] > 0) ? 1 : 0;
                    if (pp == 1) begin
                        chk($sformatf("d%0d_pop_data", d), mem[k][sel_s[k]], head[k]);
                        head[k]++;
                        rp[k] = (rp[k] + 1) % d;
                    end
                    for (int i = 0; i < 8; i++)
                        if (en_s[k][i]) mem[k][i] = wd[k];
                    if (ps == 1) begin
                        wd[k]++;
                        wp[k] = (wp[k] + 1) % d;
                    end
                    cnt[k] = cnt[k] + ps - pp;
                    if (cnt[k] > hw[k]) hw[k] = cnt[k];
                end
            end
        end
    end

    // Mid-cycle comparison of every output against the model.
    initial begin
        forever begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                int d, wr_e, rv_e, en_e;
                d    = dep(k);
                wr_e = (cnt[k] < d && !clr) ? 1 : 0;
                rv_e = (cnt[k] > 0 && !clr) ? 1 : 0;
                en_e = (rst_n && wr_valid && wr_e == 1) ? (1 << wp[k]) : 0;
                chk($sformatf("d%0d_wr_ready", d), int'(flg_a[k][5]), wr_e);
                chk($sformatf("d%0d_rd_valid", d), int'(flg_a[k][4]), rv_e);
                chk($sformatf("d%0d_full", d), int'(flg_a[k][3]), (cnt[k] == d) ? 1 : 0);
                chk($sformatf("d%0d_empty", d), int'(flg_a[k][2]), (cnt[k] == 0) ? 1 : 0);
                chk($sformatf("d%0d_almost_full", d), int'(flg_a[k][1]), (cnt[k] >= d - 2) ? 1 : 0);
                chk($sformatf("d%0d_almost_empty", d), int'(flg_a[k][0]), (cnt[k] <= 1) ? 1 : 0);
                chk($sformatf("d%0d_count", d), int'(cnt_a[k]), cnt[k]);
                chk($sformatf("d%0d_hwm", d), int'(hwm_a[k]), hw[k]);
                chk($sformatf("d%0d_rd_sel", d), int'(sel_a[k]), rp[k]);
                chk($sformatf("d%0d_slot_wr_en", d), int'(en_a[k]), en_e);
                en_s[k]  = en_a[k];
                sel_s[k] = int'(sel_a[k]);
            end
        end
    end

    // Hold the given inputs for n clock edges; returns 2 time units after the last edge.
    task automatic drive(input logic wv, input logic rr, input logic c, input int n);
        wr_valid = wv; rd_ready = rr; clr = c;
        repeat (n) @(posedge clk);
        #2;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;

        // Fill DEPTH=8 with no pops
        drive(1, 0, 0, 5); #1;
        chk("t1_count8_5", int'(count8), 5);
        chk("t1_af8_at5", int'(af8), 0);
        chk("t1_full5", int'(full5), 1);
        drive(1, 0, 0, 1); #1;
        chk("t1_af8_at6", int'(af8), 1);
        drive(1, 0, 0, 2); #1;
        chk("t1_full8", int'(full8), 1);
        chk("t1_count8_8", int'(count8), 8);
        chk("t1_wr_ready8", int'(wr_ready8), 0);
        chk("t1_hwm8", int'(hwm8), 8);

        // Drain from full; wr_valid held through the first pop
        drive(1, 1, 0, 1); #1;
        chk("t2_wr_ready8_after_pop", int'(wr_ready8), 1);
        chk("t2_count8_7", int'(count8), 7);
        drive(0, 1, 0, 7); #1;
        chk("t2_empty8", int'(empty8), 1);
        chk("t2_empty5", int'(empty5), 1);
        chk("t2_hwm8_kept", int'(hwm8), 8);

        // Steady push+pop at count 3 with pointer wrap on both depths
        drive(1, 0, 0, 3);
        drive(1, 1, 0, 20); #1;
        chk("t3_count8_3", int'(count8), 3);
        chk("t3_count5_3", int'(count5), 3);
        chk("t3_en8_slot7", int'(en8), 8'h80);
        chk("t3_en5_slot3", int'(en5), 5'b01000);
        chk("t3_rd_sel8", int'(rd_sel8), 4);
        chk("t3_rd_sel5", int'(rd_sel5), 0);

        // Flush at count 5 with both handshakes requested
        drive(1, 0, 0, 2); #1;
        chk("t5_count8_5", int'(count8), 5);
        wr_valid = 1'b1; rd_ready = 1'b1; clr = 1'b1; #1;
        chk("t5_wr_ready8_clr", int'(wr_ready8), 0);
        chk("t5_rd_valid8_clr", int'(rd_valid8), 0);
        chk("t5_en8_clr", int'(en8), 0);
        @(posedge clk); #2;
        wr_valid = 1'b0; rd_ready = 1'b0; clr = 1'b0; #1;
        chk("t5_count8_0", int'(count8), 0);
        chk("t5_empty8", int'(empty8), 1);
        chk("t5_hwm8_0", int'(hwm8), 0);
        chk("t5_hwm5_0", int'(hwm5), 0);

        // Asynchronous reset between edges in the middle of a burst
        drive(1, 0, 0, 4); #1;
        rst_n = 1'b0; #1;
        chk("t6_count8_rst", int'(count8), 0);
        chk("t6_empty8_rst", int'(empty8), 1);
        chk("t6_hwm8_rst", int'(hwm8), 0);
        chk("t6_en8_rst", int'(en8), 0);
        chk("t6_af8_rst", int'(af8), 0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        drive(1, 0, 0, 3); #1;
        chk("t6_count8_resume", int'(count8), 3);
        drive(0, 1, 0, 3); #1;
        chk("t6_empty8_resume", int'(empty8), 1);
        chk("t6_hwm8_resume", int'(hwm8), 3);

        @(posedge clk); #2;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
